agc_sequencer: RTL and testbench
================================

# agc_sequencer

Sequencer for the receive-path automatic gain control loop. Observes the received sample stream and measures the peak magnitude over fixed windows of N samples. Hands each window peak to the PID gain block through a valid/ready handshake, then blanks measurement until the new gain has propagated through the amplifier pipeline. Also reports loop lock and supports a freeze input that holds the gain during packet reception.

## Interface
- SYMBOL_WIDTH, 16: word length of samples and peak (signed Q(SYMBOL_WIDTH-SYMBOL_FRAC).SYMBOL_FRAC)
- SYMBOL_FRAC, 14: fractional bits
- WINDOW, 512: new_sample strobes per measurement window (≥2)
- SETTLE, 16: new_sample strobes discarded after a gain change (≥1; covers amplifier pipeline latency)
- TARGET, 16384: desired peak magnitude, raw fixed-point (1.0)
- LOCK_TOL, 1024: allowed |peak − TARGET|, raw
- LOCK_COUNT, 4: consecutive in-tolerance windows required for lock (≥1)
- TIMEOUT, 4096: clk cycles (while en) to wait for gain_applied before giving up
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  clock enable; when low, all state, counters and outputs hold
- new_sample  in  1  qualifies in_sample
- in_sample  in  SYMBOL_WIDTH signed  amplified received sample
- freeze  in  1  inhibit gain updates
- peak  out  SYMBOL_WIDTH signed  last window peak magnitude (non-negative)
- peak_valid  out  1  peak offered to gain block
- peak_ready  in  1  gain block accepts peak
- gain_applied  in  1  one-cycle pulse: new gain now in effect
- locked  out  1  loop within tolerance
- timeout_err  out  1  sticky; gain_applied not received within TIMEOUT
- state  out  3  current FSM state, for debug

## Operation
- Magnitude: |in_sample|; −2^(SYMBOL_WIDTH−1) saturates to 2^(SYMBOL_WIDTH−1)−1.
- States (encoding): IDLE=0, SETTLE=1, ACQUIRE=2, REPORT=3, WAIT_APPLY=4.
- IDLE:
  - Entered on rst.
  - Leaves to SETTLE on the first cycle with en=1.
- SETTLE:
  - Counts SETTLE qualified samples and ignores their values.
  - On the SETTLE-th sample: clear the running max and window counter, go to ACQUIRE.
- ACQUIRE:
  - Running max = max(running max, magnitude) on each qualified sample.
  - On the WINDOW-th sample, the max including that sample is written to peak, and the lock evaluation runs.
  - Next state: REPORT if freeze=0 at that cycle. If freeze=1, go back to ACQUIRE with the max and counter cleared; no report.
- Lock evaluation, at every window end:
  - If |peak − TARGET| ≤ LOCK_TOL, lock_cnt increments, saturating at LOCK_COUNT.
  - Otherwise lock_cnt is cleared.
  - locked = (lock_cnt == LOCK_COUNT), registered.
- REPORT:
  - peak_valid=1 and peak stable until the cycle with peak_valid && peak_ready; then go to WAIT_APPLY.
  - Samples arriving in REPORT are ignored.
  - freeze has no effect once in REPORT.
- WAIT_APPLY:
  - On gain_applied=1, go to SETTLE.
  - After TIMEOUT enabled cycles without gain_applied, set timeout_err and go to SETTLE.
  - gain_applied outside WAIT_APPLY is ignored.
- Arithmetic: the difference peak − TARGET is computed at SYMBOL_WIDTH+1 bits, so it cannot overflow.

## Timing
- Reset values: peak=0, peak_valid=0, locked=0, timeout_err=0, state=IDLE, all counters and running max 0.
- rst mid-operation, including REPORT with peak_valid high, drops to IDLE next cycle; any pending handshake is abandoned.
- Window end: peak, locked and peak_valid update on the clk edge that registers the WINDOW-th qualified sample. peak_valid is visible the cycle after that sample is presented.
- Handshake: zero-cycle acceptance allowed. peak_valid deasserts the cycle after acceptance. Ready may be high before valid.
- WAIT_APPLY: gain_applied on the first WAIT_APPLY cycle is honoured. If gain_applied and the timeout expire on the same cycle, gain_applied wins (no error).
- en=0: new_sample, peak_ready and gain_applied are ignored; timeout counter pauses.
- Full sequence per gain update: SETTLE + WINDOW qualified samples + handshake + apply latency.

## Test plan
Bench parameters: WINDOW=8, SETTLE=2, TARGET=16384, LOCK_TOL=1024, LOCK_COUNT=2, TIMEOUT=20.
- Reset, en=1, 10 samples (2 settle + 8 window) with values 100, −200, 9000, −32768, 5, 0, 7, 1 in the window → peak=32767, peak_valid rises the cycle after the 10th sample, locked=0.
- peak_ready held low 5 cycles then pulsed → peak_valid high exactly through the accept cycle; 3 extra samples sent meanwhile do not change peak.
- Two accepted windows each peaking at 16000, with gain_applied returned 3 cycles after acceptance → locked=1 after the 2nd window end. A third window peaking at 18000 → locked=0.
- freeze=1 at the end of window with peak 16384 → no peak_valid, state returns to ACQUIRE, lock count still advances.
- No gain_applied after acceptance → timeout_err=1 after 20 enabled cycles, state=SETTLE. A later gain_applied in SETTLE is ignored.
- rst asserted while peak_valid=1 → next cycle peak_valid=0, peak=0, state=IDLE.

Source files
------------

// File: rtl/agc_sequencer_if.sv
// Sample stream and peak handshake bundle between the AGC sequencer and its
// surroundings. The sequencer sits on the master side: it offers the peak
// and consumes samples, ready and the gain-applied pulse.
interface agc_sequencer_if #(
  parameter int SYMBOL_WIDTH = 16
);
  logic                           new_sample;
  logic signed [SYMBOL_WIDTH-1:0] in_sample;
  logic                           freeze;
  logic signed [SYMBOL_WIDTH-1:0] peak;
  logic                           peak_valid;
  logic                           peak_ready;
  logic                           gain_applied;

  modport master (
    input  new_sample, in_sample, freeze, peak_ready, gain_applied,
    output peak, peak_valid
  );

  modport slave (
    output new_sample, in_sample, freeze, peak_ready, gain_applied,
    input  peak, peak_valid
  );
endinterface

// File: rtl/agc_sequencer.sv
// AGC loop sequencer: settles after each gain change, measures the peak
// magnitude over a window of samples, offers it to the gain block, then waits
// for the new gain to take effect. Tracks lock and a sticky apply timeout.
module agc_sequencer #(
  parameter int SYMBOL_WIDTH = 16,
  parameter int SYMBOL_FRAC  = 14,
  parameter int WINDOW       = 512,
  parameter int SETTLE       = 16,
  parameter int TARGET       = 1 << SYMBOL_FRAC,
  parameter int LOCK_TOL     = 1024,
  parameter int LOCK_COUNT   = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  agc_sequencer_if.master      bus,
  output logic                 locked,
  output logic                 timeout_err,
  output logic [2:0]           state
);

  localparam int W    = SYMBOL_WIDTH;
  localparam int SC_W = $clog2(SETTLE + 1);
  localparam int WC_W = $clog2(WINDOW + 1);
  localparam int TC_W = $clog2(TIMEOUT + 1);
  localparam int LC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [SC_W-1:0] SETTLE_LAST  = SC_W'(SETTLE - 1);
  localparam logic [WC_W-1:0] WINDOW_LAST  = WC_W'(WINDOW - 1);
  localparam logic [TC_W-1:0] TIMEOUT_LAST = TC_W'(TIMEOUT - 1);
  localparam logic [LC_W-1:0] LOCK_FULL    = LC_W'(LOCK_COUNT);

  localparam logic signed [W-1:0] MOST_NEG   = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]        MAX_MAG    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W:0]   TARGET_EXT = (W+1)'(TARGET);
  localparam logic [W:0]          TOL_EXT    = (W+1)'(LOCK_TOL);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SETTLE     = 3'd1,
    S_ACQUIRE    = 3'd2,
    S_REPORT     = 3'd3,
    S_WAIT_APPLY = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [SC_W-1:0]  settle_cnt;
  logic [WC_W-1:0]  win_cnt;
  logic [TC_W-1:0]  to_cnt;
  logic [LC_W-1:0]  lock_cnt;
  logic [W-1:0]     run_max;
  logic signed [W-1:0] peak_q;
  logic             locked_q;
  logic             timeout_q;

  logic [W-1:0]        mag;
  logic [W-1:0]        new_max;
  logic signed [W:0]   diff;
  logic [W:0]          abs_diff;
  logic                in_tol;
  logic [LC_W-1:0]     lock_cnt_next;
  logic                qs;
  logic                settle_done;
  logic                window_end;
  logic                accept;
  logic                applied;
  logic                expired;

  // Magnitude with saturation of the most negative code, running max and
  // the lock tolerance test on the candidate window peak.
  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    mag = bus.in_sample;
    if (bus.in_sample == MOST_NEG)
      mag = MAX_MAG;
    else if (bus.in_sample[W-1])
      mag = W'(-bus.in_sample);

    new_max  = (mag > run_max) ? mag : run_max;
    diff     = $signed({1'b0, new_max}) - TARGET_EXT;
    abs_diff = diff[W] ? $unsigned(-diff) : $unsigned(diff);
    in_tol   = (abs_diff <= TOL_EXT);

    lock_cnt_next = '0;
    if (in_tol)
      lock_cnt_next = (lock_cnt == LOCK_FULL) ? lock_cnt : lock_cnt + LC_W'(1);
  end

  // Qualified events that drive both the FSM and the datapath.
  always_comb begin
    qs          = en & bus.new_sample;
    settle_done = (state_q == S_SETTLE) && qs && (settle_cnt == SETTLE_LAST);
    window_end  = (state_q == S_ACQUIRE) && qs && (win_cnt == WINDOW_LAST);
    accept      = (state_q == S_REPORT) && en && bus.peak_ready;
    applied     = (state_q == S_WAIT_APPLY) && en && bus.gain_applied;
    expired     = (state_q == S_WAIT_APPLY) && en && !bus.gain_applied
                  && (to_cnt == TIMEOUT_LAST);
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state decode; gain_applied takes priority over an expiring timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (en) state_d = S_SETTLE;
      S_SETTLE:     if (settle_done) state_d = S_ACQUIRE;
      S_ACQUIRE:    if (window_end && !bus.freeze) state_d = S_REPORT;
      S_REPORT:     if (accept) state_d = S_WAIT_APPLY;
      S_WAIT_APPLY: if (applied || expired) state_d = S_SETTLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state and datapath registers.
  always_comb begin
    bus.peak_valid = (state_q == S_REPORT);
    bus.peak       = peak_q;
    locked         = locked_q;
    timeout_err    = timeout_q;
    state          = state_q;
  end

  // Counters, running max, peak and lock tracking; everything holds while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      win_cnt    <= '0;
      to_cnt     <= '0;
      lock_cnt   <= '0;
      run_max    <= '0;
      peak_q     <= '0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (en) begin
      case (state_q)
        S_SETTLE: begin
          if (settle_done) begin
            settle_cnt <= '0;
            run_max    <= '0;
            win_cnt    <= '0;
          end else if (qs) begin
            settle_cnt <= settle_cnt + SC_W'(1);
          end
        end
        S_ACQUIRE: begin
          if (window_end) begin
            peak_q   <= $signed(new_max);
            run_max  <= '0;
            win_cnt  <= '0;
            lock_cnt <= lock_cnt_next;
            locked_q <= (lock_cnt_next == LOCK_FULL);
          end else if (qs) begin
            run_max <= new_max;
            win_cnt <= win_cnt + WC_W'(1);
          end
        end
        S_WAIT_APPLY: begin
          if (applied) begin
            to_cnt <= '0;
          end else if (expired) begin
            to_cnt    <= '0;
            timeout_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_sequencer.sv
// Directed bench for agc_sequencer with small window/settle/timeout values.
module tb_agc_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic locked;
  logic timeout_err;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  agc_sequencer_if #(.SYMBOL_WIDTH(16)) bus ();

  agc_sequencer #(
    .SYMBOL_WIDTH(16), .SYMBOL_FRAC(14), .WINDOW(8), .SETTLE(2),
    .TARGET(16384), .LOCK_TOL(1024), .LOCK_COUNT(2), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus),
    .locked(locked), .timeout_err(timeout_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic signed [15:0] v);
    bus.new_sample = 1'b1;
    bus.in_sample  = v;
    step();
    bus.new_sample = 1'b0;
  endtask

  // Eight samples whose largest magnitude is |pk|.
  task automatic window8(input logic signed [15:0] pk);
    sample(pk / 4);
    sample(-(pk / 2));
    sample(pk);
    sample(16'sd3);
    sample(-16'sd7);
    sample(pk / 3);
    sample(16'sd0);
    sample(16'sd1);
  endtask

  task automatic apply_after_3();
    step();
    step();
    bus.gain_applied = 1'b1;
    step();
    bus.gain_applied = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    bus.new_sample = 1'b0; bus.in_sample = '0; bus.freeze = 1'b0;
    bus.peak_ready = 1'b0; bus.gain_applied = 1'b0;
    step(); step();

    check("rst_peak", bus.peak, 0);
    check("rst_valid", bus.peak_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_state", state, 0);

    rst = 1'b0;
    step();
    check("idle_hold", state, 0);
    en = 1'b1;
    step();
    check("to_settle", state, 1);

    // First window: saturating -32768 dominates
    sample(16'sd30000); sample(-16'sd5);
    check("to_acquire", state, 2);
    sample(16'sd100); sample(-16'sd200); sample(16'sd9000); sample(-16'sd32768);
    sample(16'sd5); sample(16'sd0); sample(16'sd7);
    check("w1_not_yet_valid", bus.peak_valid, 0);
    sample(16'sd1);
    check("w1_peak", bus.peak, 32767);
    check("w1_valid", bus.peak_valid, 1);
    check("w1_state", state, 3);
    check("w1_locked", locked, 0);

    // Ready held low; samples in REPORT are ignored
    for (int i = 0; i < 5; i++) begin
      if (i < 3) sample(16'(20000 + i));
      else step();
    end
    check("hold_valid", bus.peak_valid, 1);
    check("hold_peak", bus.peak, 32767);
    bus.peak_ready = 1'b1;
    check("accept_cycle_valid", bus.peak_valid, 1);
    step();
    bus.peak_ready = 1'b0;
    check("after_accept_valid", bus.peak_valid, 0);
    check("after_accept_state", state, 4);
    apply_after_3();
    check("applied_state", state, 1);

    // Window A: 16000, ready already high before valid
    bus.peak_ready = 1'b1;
    sample(16'sd20); sample(16'sd20);
    window8(16'sd16000);
    check("wa_peak", bus.peak, 16000);
    check("wa_valid", bus.peak_valid, 1);
    check("wa_locked", locked, 0);
    step();
    bus.peak_ready = 1'b0;
    check("wa_accept_state", state, 4);
    check("wa_accept_valid", bus.peak_valid, 0);
    apply_after_3();
    check("wa_applied", state, 1);

    // Window B: negative peak -16000 -> second in-tolerance window
    sample(16'sd20); sample(16'sd20);
    window8(-16'sd16000);
    check("wb_peak", bus.peak, 16000);
    check("wb_locked", locked, 1);
    bus.peak_ready = 1'b1; step(); bus.peak_ready = 1'b0;
    apply_after_3();

    // Window C: 18000 out of tolerance
    sample(16'sd20); sample(16'sd20);
    window8(16'sd18000);
    check("wc_peak", bus.peak, 18000);
    check("wc_locked", locked, 0);
    bus.peak_ready = 1'b1; step(); bus.peak_ready = 1'b0;
    apply_after_3();

    // Frozen windows: peak updates, lock advances, no report
    sample(16'sd20); sample(16'sd20);
    bus.freeze = 1'b1;
    window8(16'sd16384);
    check("fz1_peak", bus.peak, 16384);
    check("fz1_valid", bus.peak_valid, 0);
    check("fz1_state", state, 2);
    check("fz1_locked", locked, 0);
    window8(16'sd16500);
    check("fz2_peak", bus.peak, 16500);
    check("fz2_locked", locked, 1);
    check("fz2_state", state, 2);
    bus.freeze = 1'b0;
    window8(16'sd16384);
    check("wd_valid", bus.peak_valid, 1);
    check("wd_state", state, 3);
    check("wd_locked", locked, 1);
    bus.freeze = 1'b1;
    step();
    check("freeze_in_report", state, 3);
    bus.freeze = 1'b0;

    // Timeout with an en=0 pause in the middle
    bus.peak_ready = 1'b1; step(); bus.peak_ready = 1'b0;
    check("to_wait", state, 4);
    repeat (10) step();
    en = 1'b0;
    bus.gain_applied = 1'b1;
    repeat (5) step();
    bus.gain_applied = 1'b0;
    en = 1'b1;
    check("to_paused_state", state, 4);
    repeat (9) step();
    check("to_19_state", state, 4);
    check("to_19_err", timeout_err, 0);
    step();
    check("to_20_state", state, 1);
    check("to_20_err", timeout_err, 1);
    bus.gain_applied = 1'b1; step(); bus.gain_applied = 1'b0;
    check("late_apply_state", state, 1);
    check("late_apply_err", timeout_err, 1);

    // Reset while peak_valid is high
    sample(16'sd20); sample(16'sd20);
    window8(16'sd5000);
    check("pre_rst_valid", bus.peak_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", bus.peak_valid, 0);
    check("mid_rst_peak", bus.peak, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_err", timeout_err, 0);
    check("mid_rst_locked", locked, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
